// File: rtl/i2c_pkg.sv
// i2c_pkg: shared types and constants for the I2C byte engines.
//   i2c_tx_state_t : transmitter FSM states
//   I2C_ACK/NACK   : bit-9 SDA level meaning
//   cnt_width()    : register width that holds 0..max_val
`timescale 1ns/1ps
package i2c_pkg;

    typedef enum logic [1:0] {
        kTxIdle,
        kTxSetup,
        kTxData,
        kTxAck
    } i2c_tx_state_t;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/i2c_sync_edge.sv
// i2c_sync_edge: multi-flop synchroniser for an asynchronous bus line plus
// one-cycle rise/fall pulses on the synchronised level.
//   clk   in  system clock
//   rstn  in  synchronous active-low reset (chain preset to 1 = idle bus)
//   din   in  asynchronous pin level
//   level out synchronised level
//   rise  out one-cycle pulse when level goes 0->1
//   fall  out one-cycle pulse when level goes 1->0
`timescale 1ns/1ps
module i2c_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [SYNC_STAGES-1:0] sync_next;
    logic                   prev_reg;

    assign sync_next[0] = din;

    generate
        for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_stage
            assign sync_next[gi] = sync_reg[gi-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sync_reg <= '1;
            prev_reg <= 1'b1;
        end else begin
            sync_reg <= sync_next;
            prev_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    assign level = sync_reg[SYNC_STAGES-1];
    assign rise  = level & ~prev_reg;
    assign fall  = ~level & prev_reg;

endmodule

// File: rtl/i2c_tx.sv
// i2c_tx: I2C byte transmitter. Shifts one byte MSB-first onto SDA
// (open-drain, pull-low only) following an external SCL, releases SDA for
// bit 9 and reports the far side's ACK/NACK.
// Optional build macro: I2C_TX_ARB_EN enables arbitration-loss detection.
// Ports:
//   clk, rstn            clock, synchronous active-low reset
//   scl_i, sda_i         asynchronous bus levels
//   sda_oe               1 = pull SDA low
//   tx_data, tx_valid    byte request (accepted on tx_valid & tx_ready)
//   tx_ready             high only when idle and not aborting
//   abort                force idle and release SDA
//   busy                 state != idle
//   ack_valid, ack_nack  bit-9 result pulse / held value
//   arb_lost             arbitration-loss pulse (0 unless I2C_TX_ARB_EN)
`timescale 1ns/1ps
module i2c_tx
    import i2c_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       abort,
    output logic       busy,
    output logic       ack_valid,
    output logic       ack_nack,
    output logic       arb_lost
);

    localparam int             HW       = cnt_width(HOLD_CYCLES);
    localparam logic [HW-1:0]  HOLD_MAX = HW'(HOLD_CYCLES);

    logic scl_s, scl_rise, scl_fall;
    logic sda_s, sda_rise_unused, sda_fall_unused;

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
        .clk   (clk),
        .rstn  (rstn),
        .din   (scl_i),
        .level (scl_s),
        .rise  (scl_rise),
        .fall  (scl_fall)
    );

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
        .clk   (clk),
        .rstn  (rstn),
        .din   (sda_i),
        .level (sda_s),
        .rise  (sda_rise_unused),
        .fall  (sda_fall_unused)
    );

    i2c_tx_state_t state_reg, state_next;
    logic [7:0]    shreg_reg, shreg_next;
    logic [2:0]    bit_cnt_reg, bit_cnt_next;
    logic [HW-1:0] hold_cnt_reg, hold_cnt_next;
    // Set by an SCL fall in DATA; the hold timer only fires while armed so a
    // saturated counter does not re-trigger a shift.
    logic          hold_run_reg, hold_run_next;
    logic          sda_oe_reg, sda_oe_next;
    logic          ack_valid_reg, ack_valid_next;
    logic          ack_nack_reg, ack_nack_next;
    logic          accept;
    logic          hold_done;

    assign tx_ready  = rstn & ~abort & (state_reg == kTxIdle);
    assign accept    = tx_valid & tx_ready;
    assign hold_done = (hold_cnt_reg == HOLD_MAX);

`ifdef I2C_TX_ARB_EN
    logic arb_lost_reg, arb_lost_next;
`endif

    always_comb begin
        state_next     = state_reg;
        shreg_next     = shreg_reg;
        bit_cnt_next   = bit_cnt_reg;
        hold_cnt_next  = hold_cnt_reg;
        hold_run_next  = hold_run_reg;
        sda_oe_next    = sda_oe_reg;
        ack_valid_next = 1'b0;
        ack_nack_next  = ack_nack_reg;
`ifdef I2C_TX_ARB_EN
        arb_lost_next  = 1'b0;
`endif
        if (abort) begin
            state_next    = kTxIdle;
            sda_oe_next   = 1'b0;
            hold_cnt_next = '0;
            hold_run_next = 1'b0;
            bit_cnt_next  = 3'd7;
        end else begin
            case (state_reg)
                kTxIdle: begin
                    sda_oe_next = 1'b0;
                    if (accept) begin
                        shreg_next    = tx_data;
                        bit_cnt_next  = 3'd7;
                        hold_cnt_next = '0;
                        hold_run_next = 1'b0;
                        state_next    = kTxSetup;
                    end
                end
                kTxSetup: begin
                    // The first bit may only go out once SCL is (still) low
                    // for the full hold time.
                    if (!scl_s) begin
                        if (hold_done) begin
                            sda_oe_next = ~shreg_reg[7];
                            state_next  = kTxData;
                        end else begin
                            hold_cnt_next = hold_cnt_reg + HW'(1);
                        end
                    end else begin
                        hold_cnt_next = '0;
                    end
                end
                kTxData: begin
`ifdef I2C_TX_ARB_EN
                    if (scl_rise && !sda_oe_reg && !sda_s) begin
                        arb_lost_next = 1'b1;
                        sda_oe_next   = 1'b0;
                        hold_run_next = 1'b0;
                        state_next    = kTxIdle;
                    end else
`endif
                    if (scl_fall) begin
                        hold_cnt_next = '0;
                        hold_run_next = 1'b1;
                    end else if (hold_run_reg && !scl_s) begin
                        if (hold_done) begin
                            hold_run_next = 1'b0;
                            if (bit_cnt_reg == 3'd0) begin
                                sda_oe_next = 1'b0;   // release for bit 9
                                state_next  = kTxAck;
                            end else begin
                                shreg_next   = {shreg_reg[6:0], 1'b0};
                                bit_cnt_next = bit_cnt_reg - 3'd1;
                                sda_oe_next  = ~shreg_reg[6];
                            end
                        end else begin
                            hold_cnt_next = hold_cnt_reg + HW'(1);
                        end
                    end
                end
                kTxAck: begin
                    if (scl_rise) begin
                        ack_valid_next = 1'b1;
                        ack_nack_next  = sda_s ? I2C_NACK : I2C_ACK;
                        state_next     = kTxIdle;
                    end
                end
                default: state_next = kTxIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg     <= kTxIdle;
            shreg_reg     <= '0;
            bit_cnt_reg   <= 3'd7;
            hold_cnt_reg  <= '0;
            hold_run_reg  <= 1'b0;
            sda_oe_reg    <= 1'b0;
            ack_valid_reg <= 1'b0;
            ack_nack_reg  <= I2C_NACK;
        end else begin
            state_reg     <= state_next;
            shreg_reg     <= shreg_next;
            bit_cnt_reg   <= bit_cnt_next;
            hold_cnt_reg  <= hold_cnt_next;
            hold_run_reg  <= hold_run_next;
            sda_oe_reg    <= sda_oe_next;
            ack_valid_reg <= ack_valid_next;
            ack_nack_reg  <= ack_nack_next;
        end
    end

`ifdef I2C_TX_ARB_EN
    always_ff @(posedge clk) begin
        if (!rstn) begin
            arb_lost_reg <= 1'b0;
        end else begin
            arb_lost_reg <= arb_lost_next;
        end
    end
    assign arb_lost = arb_lost_reg;
`else
    assign arb_lost = 1'b0;
`endif

    assign sda_oe    = sda_oe_reg;
    assign busy      = (state_reg != kTxIdle);
    assign ack_valid = ack_valid_reg;
    assign ack_nack  = ack_nack_reg;

endmodule

// File: tb/tb_i2c_tx.sv
`timescale 1ns/1ps
module tb_i2c_tx;

    localparam int SCL_HALF = 5000;     // 100 kHz SCL, in ns
    localparam int STRETCH  = 50000;    // 50 us clock stretch

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       scl = 1'b1;
    logic       resp_pull = 1'b0;
    logic       force_low = 1'b0;
    logic       abort = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       sda_oe, tx_ready, busy, ack_valid, ack_nack, arb_lost;
    logic       sda_line;

    assign sda_line = ~(sda_oe | resp_pull | force_low);

    always #25 clk = ~clk;   // 20 MHz

    i2c_tx #(.HOLD_CYCLES(4), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .scl_i     (scl),
        .sda_i     (sda_line),
        .sda_oe    (sda_oe),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .abort     (abort),
        .busy      (busy),
        .ack_valid (ack_valid),
        .ack_nack  (ack_nack),
        .arb_lost  (arb_lost)
    );

    int          n_cmp = 0;
    int          n_fail = 0;
    int unsigned cyc = 0;
    int          arb_cnt = 0;
    logic        mon_en = 1'b0;
    logic [7:0]  exp_byte_q[$];
    logic        exp_ack_q[$];
    logic        obs_ack_q[$];
    int unsigned obs_ack_cyc_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rstn === 1'b1 && ack_valid === 1'b1) begin
            obs_ack_q.push_back(ack_nack);
            obs_ack_cyc_q.push_back(cyc);
        end
        if (arb_lost === 1'b1) arb_cnt <= arb_cnt + 1;
    end

    // SDA driven by the DUT must only move while SCL is low.
    always @(sda_oe) begin
        if (mon_en) begin
            n_cmp++;
            if (scl !== 1'b0) begin
                n_fail++;
                $display("FAIL sda_stable: sda_oe changed to %0b with scl=%0b, required scl=0", sda_oe, scl);
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1, "watchdog");
    end

    // One SCL bit: low phase (optionally stretched), high phase sampled mid-way.
    task automatic scl_bit(input logic resp_low, input logic force_it, input int stretch_ns,
                           output logic b);
        #(SCL_HALF/2);
        resp_pull = resp_low;
        if (force_it) force_low = 1'b1;
        #(SCL_HALF/2 + stretch_ns);
        scl = 1'b1;
        #(SCL_HALF/2);
        b = sda_line;
        #(SCL_HALF/2);
        scl = 1'b0;
        #100;
        resp_pull = 1'b0;
        force_low = 1'b0;
    endtask

    task automatic scl_byte(input logic resp_ack, input int stretch_bit, input int force_bit,
                            output logic [7:0] data, output logic ninth);
        logic b;
        data = 8'h00;
        ninth = 1'b1;
        for (int i = 0; i < 9; i++) begin
            scl_bit((i == 8) && resp_ack, (i == force_bit), (i == stretch_bit) ? STRETCH : 0, b);
            if (i < 8) data = {data[6:0], b};
            else       ninth = b;
        end
    endtask

    task automatic send(input logic [7:0] d, input logic exp_ack, output logic ok);
        ok = 1'b0;
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            if (tx_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (ok) begin
            @(posedge clk);
            #1;
            tx_valid = 1'b0;
            exp_byte_q.push_back(d);
            exp_ack_q.push_back(exp_ack);
        end else begin
            tx_valid = 1'b0;
            n_fail++;
            $display("FAIL accept: tx_ready=%0b after 200 clk for 0x%02h, required 1", tx_ready, d);
        end
    endtask

    // Full transaction: send, clock the byte, then check bus byte, bit-9, ack report.
    task automatic run_byte(input logic [7:0] d, input logic resp_ack, input int stretch_bit,
                            input string tag);
        logic ok, ninth, exp_a;
        logic [7:0] got, exp_b;
        obs_ack_q.delete();
        obs_ack_cyc_q.delete();
        send(d, ~resp_ack, ok);
        if (!ok) return;
        scl_byte(resp_ack, stretch_bit, -1, got, ninth);
        #1000;
        exp_b = exp_byte_q.pop_front();
        exp_a = exp_ack_q.pop_front();
        n_cmp++;
        if (got !== exp_b) begin
            n_fail++;
            $display("FAIL %s_byte: bus 0x%02h, required 0x%02h", tag, got, exp_b);
        end
        n_cmp++;
        if (ninth !== exp_a) begin
            n_fail++;
            $display("FAIL %s_bit9: bus %0b, required %0b", tag, ninth, exp_a);
        end
        n_cmp++;
        if (obs_ack_q.size() != 1) begin
            n_fail++;
            $display("FAIL %s_ack_count: %0d ack_valid pulses, required 1", tag, obs_ack_q.size());
        end else begin
            n_cmp++;
            if (obs_ack_q[0] !== exp_a) begin
                n_fail++;
                $display("FAIL %s_ack_nack: got %0b, required %0b", tag, obs_ack_q[0], exp_a);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (tx_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_idle: tx_ready=%0b busy=%0b, required 1/0", tag, tx_ready, busy);
        end
        $display("txn %s: sent 0x%02h bus 0x%02h ack_nack %0b", tag, d, got, exp_a);
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (sda_oe !== 1'b0 || busy !== 1'b0 || ack_valid !== 1'b0 || arb_lost !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: sda_oe=%0b busy=%0b ack_valid=%0b arb_lost=%0b, required all 0",
                     sda_oe, busy, ack_valid, arb_lost);
        end
        n_cmp++;
        if (ack_nack !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ack_nack: got %0b, required 1", ack_nack);
        end
        rstn = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (tx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_tx_ready: got %0b, required 1", tx_ready);
        end
        $display("txn reset: done");
        scl = 1'b0;   // bus owned by the controller after its START
        #1000;
        mon_en = 1'b1;
    endtask

    task automatic test_ack;
        run_byte(8'hA5, 1'b1, -1, "ack");
    endtask

    task automatic test_nack;
        run_byte(8'h3C, 1'b0, -1, "nack");
    endtask

    task automatic test_back_to_back;
        int unsigned acc_cyc[2];
        int acc;
        logic [7:0] got0, got1, e;
        logic n0, n1, ea;
        obs_ack_q.delete();
        obs_ack_cyc_q.delete();
        acc = 0;
        fork
            begin
                @(negedge clk);
                tx_data  = 8'hFF;
                tx_valid = 1'b1;
                for (int k = 0; k < 20000 && acc < 2; k++) begin
                    if (tx_ready === 1'b1) begin
                        acc_cyc[acc] = cyc + 1;
                        exp_byte_q.push_back(tx_data);
                        exp_ack_q.push_back(1'b0);
                        acc++;
                        @(posedge clk);
                        #1;
                        if (acc == 1) tx_data = 8'h00;
                    end
                    @(negedge clk);
                end
                tx_valid = 1'b0;
            end
            begin
                scl_byte(1'b1, -1, -1, got0, n0);
                scl_byte(1'b1, -1, -1, got1, n1);
            end
        join
        #1000;
        n_cmp++;
        if (acc != 2 || obs_ack_q.size() != 2) begin
            n_fail++;
            $display("FAIL b2b_count: %0d accepts %0d acks, required 2/2", acc, obs_ack_q.size());
            exp_byte_q.delete();
            exp_ack_q.delete();
            return;
        end
        e = exp_byte_q.pop_front();
        ea = exp_ack_q.pop_front();
        n_cmp++;
        if (got0 !== e || obs_ack_q[0] !== ea) begin
            n_fail++;
            $display("FAIL b2b_first: bus 0x%02h ack %0b, required 0x%02h/%0b", got0, obs_ack_q[0], e, ea);
        end
        e = exp_byte_q.pop_front();
        ea = exp_ack_q.pop_front();
        n_cmp++;
        if (got1 !== e || obs_ack_q[1] !== ea) begin
            n_fail++;
            $display("FAIL b2b_second: bus 0x%02h ack %0b, required 0x%02h/%0b", got1, obs_ack_q[1], e, ea);
        end
        n_cmp++;
        if (acc_cyc[1] != obs_ack_cyc_q[0] + 1) begin
            n_fail++;
            $display("FAIL b2b_accept_cycle: accepted at clk %0d, required %0d",
                     acc_cyc[1], obs_ack_cyc_q[0] + 1);
        end
        $display("txn b2b: bus 0x%02h then 0x%02h, second accept clk %0d", got0, got1, acc_cyc[1]);
    endtask

    task automatic test_stretch;
        run_byte(8'h81, 1'b1, 4, "stretch");
    endtask

    task automatic test_reset_mid;
        logic ok, b;
        obs_ack_q.delete();
        send(8'h00, 1'b0, ok);
        for (int i = 0; i < 3; i++) scl_bit(1'b0, 1'b0, 0, b);
        #(SCL_HALF/2);
        @(negedge clk);
        n_cmp++;
        if (sda_oe !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_pre: sda_oe=%0b before reset, required 1", sda_oe);
        end
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        n_cmp++;
        if (sda_oe !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_release: sda_oe=%0b busy=%0b, required 0/0", sda_oe, busy);
        end
        #(SCL_HALF);
        n_cmp++;
        if (obs_ack_q.size() != 0) begin
            n_fail++;
            $display("FAIL rstmid_no_ack: %0d ack_valid pulses, required 0", obs_ack_q.size());
        end
        exp_byte_q.delete();
        exp_ack_q.delete();
        $display("txn rstmid: reset during bit 3");
        run_byte(8'h5A, 1'b1, -1, "after_rst");
    endtask

    task automatic test_abort;
        logic ok, b;
        @(negedge clk);
        abort    = 1'b1;
        tx_valid = 1'b1;
        tx_data  = 8'h77;
        #1;
        n_cmp++;
        if (tx_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_ready: tx_ready=%0b with abort, required 0", tx_ready);
        end
        @(negedge clk);
        abort    = 1'b0;
        tx_valid = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_wins: busy=%0b after abort+tx_valid, required 0", busy);
        end
        send(8'h00, 1'b0, ok);
        for (int i = 0; i < 2; i++) scl_bit(1'b0, 1'b0, 0, b);
        #(SCL_HALF/2);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_cmp++;
        if (sda_oe !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_mid: sda_oe=%0b busy=%0b, required 0/0", sda_oe, busy);
        end
        exp_byte_q.delete();
        exp_ack_q.delete();
        #(SCL_HALF);
        $display("txn abort: idle and mid-byte aborts");
    endtask

    task automatic test_arb;
        logic ok, ninth;
        logic [7:0] got;
        int arb0;
        obs_ack_q.delete();
        arb0 = arb_cnt;
        send(8'h80, 1'b0, ok);
        scl_byte(1'b1, -1, 0, got, ninth);
        #1000;
        @(negedge clk);
`ifdef I2C_TX_ARB_EN
        n_cmp++;
        if (arb_cnt - arb0 != 1) begin
            n_fail++;
            $display("FAIL arb_pulse: %0d arb_lost cycles, required 1", arb_cnt - arb0);
        end
        n_cmp++;
        if (obs_ack_q.size() != 0 || busy !== 1'b0 || sda_oe !== 1'b0) begin
            n_fail++;
            $display("FAIL arb_idle: acks=%0d busy=%0b sda_oe=%0b, required 0/0/0",
                     obs_ack_q.size(), busy, sda_oe);
        end
        n_cmp++;
        if (got !== 8'h7F) begin
            n_fail++;
            $display("FAIL arb_release: bus 0x%02h, required 0x7f", got);
        end
`else
        n_cmp++;
        if (arb_cnt - arb0 != 0) begin
            n_fail++;
            $display("FAIL arb_disabled: %0d arb_lost cycles, required 0", arb_cnt - arb0);
        end
        n_cmp++;
        if (obs_ack_q.size() != 1 || got !== 8'h00) begin
            n_fail++;
            $display("FAIL arb_ignored: acks=%0d bus 0x%02h, required 1/0x00", obs_ack_q.size(), got);
        end else begin
            n_cmp++;
            if (obs_ack_q[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL arb_ack: ack_nack=%0b, required 0", obs_ack_q[0]);
            end
        end
`endif
        exp_byte_q.delete();
        exp_ack_q.delete();
        $display("txn arb: sent 0x80 bus 0x%02h arb_lost cycles %0d", got, arb_cnt - arb0);
    endtask

    initial begin
        test_reset();
        test_ack();
        test_nack();
        test_back_to_back();
        test_stretch();
        test_reset_mid();
        test_abort();
        test_arb();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
